// File: rtl/bht_predictor_param.sv
// Fetch-stage branch predictor: decodes branch/jump/hlt, predicts from a table of
// saturating counters and tracks predicted branches in a circular in-flight queue.

module bht_ctr_cell #(
  parameter int                  CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [CTR_BITS-1:0] wdata,
  output logic [CTR_BITS-1:0] ctr
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   ctr <= RST_VAL;
    else if (we) ctr <= wdata;
  end
endmodule

module bht_predictor_param #(
  parameter int IDX_BITS   = 5,
  parameter int CTR_BITS   = 2,
  parameter int QDEPTH     = 4,
  parameter int FAST_TRAIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc4_f,
  input  logic        fetch_valid,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        is_branch,
  output logic        jump,
  output logic        hlt,
  output logic        predict_taken,
  output logic [31:0] npc_f,
  output logic        queue_full,
  output logic        mispredict,
  output logic        kill_decode,
  output logic [31:0] correct_pc,
  output logic        resolve_err
);
  localparam int TBL = 1 << IDX_BITS;
  localparam int PW  = $clog2(QDEPTH);
  localparam logic [CTR_BITS-1:0] CTR_MID = CTR_BITS'(1) << (CTR_BITS-1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MID - CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                pred;
    logic [31:0]         pc4;
    logic [31:0]         npc;
  } q_entry_t;

  logic [TBL-1:0][CTR_BITS-1:0] ctr_q;
  logic [TBL-1:0]               tbl_we;
  logic [CTR_BITS-1:0]          wr_ctr, rd_ctr;
  logic [IDX_BITS-1:0]          idx_f;
  logic [5:0]                   opc;

  q_entry_t       q_mem [QDEPTH];
  q_entry_t       head;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [PW:0]    q_count;
  logic           pop, push, flush;

  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] c, input logic t);
    // Weak states jump straight to the saturated end when fast training is on.
    if (FAST_TRAIN != 0 && (c == CTR_WNT || c == CTR_MID)) return t ? CTR_MAX : '0;
    if (t) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  assign opc   = instr_f[31:26];
  assign idx_f = pc4_f[IDX_BITS+1:2];
  assign head  = q_mem[rd_ptr];

  always_comb begin
    is_branch = 1'b0;
    jump      = 1'b0;
    hlt       = 1'b0;
    npc_f     = '0;
    case (opc)
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        is_branch = 1'b1;
        npc_f     = pc4_f + {{14{instr_f[15]}}, instr_f[15:0], 2'b00};
      end
      6'h02, 6'h03: begin
        jump  = 1'b1;
        npc_f = {pc4_f[31:28], instr_f[25:0], 2'b00};
      end
      6'h3C:   hlt = 1'b1;
      default: ;
    endcase
  end

  assign queue_full = (q_count == (PW+1)'(QDEPTH));
  assign pop        = resolve_valid && (q_count != '0);
  assign flush      = pop && (head.pred != resolve_taken);
  assign wr_ctr     = ctr_next(ctr_q[head.idx], resolve_taken);
  // Write-first: a resolve training the fetched index this cycle is seen immediately.
  assign rd_ctr        = (pop && head.idx == idx_f) ? wr_ctr : ctr_q[idx_f];
  assign predict_taken = is_branch && (rd_ctr >= CTR_MID);
  assign push          = fetch_valid && is_branch && (!queue_full || pop) && !flush;

  always_comb begin
    tbl_we = '0;
    if (pop) tbl_we[head.idx] = 1'b1;
  end

  for (genvar i = 0; i < TBL; i++) begin : g_tbl
    bht_ctr_cell #(.CTR_BITS(CTR_BITS), .RST_VAL(CTR_WNT)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .we    (tbl_we[i]),
      .wdata (wr_ctr),
      .ctr   (ctr_q[i])
    );
  end

  // Entry storage needs no reset: q_count gates every read.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{idx: idx_f, pred: predict_taken, pc4: pc4_f, npc: npc_f};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + (PW+1)'(1);
        2'b01:   q_count <= q_count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict  <= 1'b0;
      kill_decode <= 1'b0;
      correct_pc  <= '0;
      resolve_err <= 1'b0;
    end else begin
      mispredict  <= flush;
      kill_decode <= flush;
      if (flush) correct_pc <= resolve_taken ? head.npc : head.pc4;
      if (resolve_valid && q_count == '0) resolve_err <= 1'b1;
    end
  end
endmodule
